// File: rtl/motor_pkg.sv
// motor_pkg: widths, codes and states shared along the encoder period -> speed path
package motor_pkg;
    localparam int PERIOD_W = 24;
    localparam int SPEED_W = 8;
    localparam logic [PERIOD_W-1:0] PERIOD_STALL = 24'hFFFFFF;
    localparam int unsigned PERIOD_MAX_DEFAULT = 3265095;
    localparam int unsigned PERIOD_MIN_FULL = 12804;
    typedef enum logic {IDLE, MEASURE} meter_state_t;
endpackage

// File: rtl/enc_edge_filter.sv
// enc_edge_filter: synchronizes, debounces and rising-edge-detects one encoder/hall input
module enc_edge_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);
    localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);
    logic r_sync0, r_sync1, r_level, r_level_d, r_rise;
    logic [3:0] r_run;
    logic w_differs;
    assign w_differs = r_sync1 != r_level;
    // synchronizer, run-length debounce, and a rise pulse taken one stage behind the level for a fixed latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_run     <= 4'd0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync0   <= i_raw;
            r_sync1   <= r_sync0;
            r_run     <= (w_differs && r_run != RUN_LAST) ? r_run + 4'd1 : 4'd0;
            r_level   <= (w_differs && r_run == RUN_LAST) ? r_sync1 : r_level;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end
    assign o_rise = r_rise;
endmodule

// File: rtl/enc_period_meter.sv
// enc_period_meter: measures encoder rising-edge spacing as a 24-bit period, reporting stalls as all-ones
module enc_period_meter
    import motor_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned DIV_SHIFT   = 0,
    parameter int unsigned STALL_LIMIT = PERIOD_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enc_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled
);
    localparam int unsigned CNT_W = PERIOD_W + DIV_SHIFT;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((longint'(STALL_LIMIT) + 1) << DIV_SHIFT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PERIOD_W-1:0] PERIOD_CAP = PERIOD_W'(STALL_LIMIT);
    meter_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic r_valid, r_stalled;
    logic w_event, w_at_limit;
    logic [PERIOD_W-1:0] w_scaled, w_publish;

    enc_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk   (clk),
        .rst   (rst),
        .i_raw (enc_in),
        .o_rise(w_event)
    );

    assign w_at_limit = r_cnt == CNT_LIMIT;
    assign w_scaled = PERIOD_W'(r_cnt >> DIV_SHIFT);

    // keep published periods inside 1..STALL_LIMIT; only a same-cycle limit hit or a coarse prescale can leave it
    always_comb begin
        w_publish = (w_scaled > PERIOD_CAP) ? PERIOD_CAP : ((w_scaled == '0) ? PERIOD_W'(1) : w_scaled);
    end

    // edge-to-edge counter plus IDLE/MEASURE control; an event beats a limit hit in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= PERIOD_STALL;
            r_valid   <= 1'b0;
            r_stalled <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            r_cnt   <= w_event ? CNT_ONE : (w_at_limit ? r_cnt : r_cnt + CNT_ONE);
            if (r_state == IDLE) begin
                r_state <= w_event ? MEASURE : IDLE;
            end else if (w_event) begin
                r_period  <= w_publish;
                r_valid   <= 1'b1;
                r_stalled <= 1'b0;
            end else if (w_at_limit) begin
                r_period  <= PERIOD_STALL;
                r_valid   <= 1'b1;
                r_stalled <= 1'b1;
                r_state   <= IDLE;
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign stalled      = r_stalled;
endmodule
